// File: rtl/dac_write_scheduler_pkg.sv
// Shared types and widths for the DAC8820 write scheduler.
package dac_write_scheduler_pkg;

   localparam int DAC_W          = 16;
   localparam int PERIOD_W       = 28;
   localparam int MODE_W         = 3;
   localparam int MIN_PERIOD_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      ST_LOAD
   } wr_state_t;

   // Periods below the write-sequence length (including 0) are raised to the floor.
   function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p,
                                                      input logic [PERIOD_W-1:0] p_min);
      return (p < p_min) ? p_min : p;
   endfunction

endpackage

// File: rtl/dac_write_scheduler_btn_debounce.sv
// Button synchronizer and debouncer; pulses o_press for one clock on an
// accepted press (released -> pressed) of the active-low button.
module dac_write_scheduler_btn_debounce #(
   parameter int DEB_CYC = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   localparam int                CNT_W    = $clog2(DEB_CYC) + 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEB_CYC - 1);

   logic [1:0]       r_sync;
   logic             w_sync;
   logic             r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   assign w_sync  = r_sync[1];
   assign o_press = r_press;

   // Two-flop synchronizer; idles at the released level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], i_btn_n};
   end

   // Down-counter restarts on agreement; accepted level flips at terminal count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc   <= 1'b1;
         r_cnt   <= CNT_LOAD;
         r_press <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (w_sync == r_acc) begin
            r_cnt <= CNT_LOAD;
         end else if (r_cnt == '0) begin
            r_acc   <= w_sync;
            r_cnt   <= CNT_LOAD;
            r_press <= ~w_sync;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dac_write_scheduler.sv
// DAC8820 write scheduler: tick generation from a shadowed period, one sample
// fetch per tick, CS/WR/LDAC strobe sequencing, overrun flag, and the
// debounced frequency-mode selector.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | waiting for a tick; tick latches sample and acks
// ST_SETUP | cs_n low, data settling before the write strobe
// ST_WRITE | cs_n and wr_n low for WR_CYC clocks
// ST_HOLD  | wr_n high (data latched), cs_n still low
// ST_LOAD  | cs_n high, ldac_n low for LDAC_CYC clocks
module dac_write_scheduler
   import dac_write_scheduler_pkg::*;
#(
   parameter int WR_CYC     = 2,
   parameter int LDAC_CYC   = 2,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF,
   parameter int DEB_CYC    = 500000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_btn_n,
   output logic [MODE_W-1:0]   o_mode,
   input  logic [PERIOD_W-1:0] i_period_in,
   input  logic                i_enable,
   input  logic [DAC_W-1:0]    i_sample_in,
   output logic                o_sample_ack,
   output logic [DAC_W-1:0]    o_dac_data,
   output logic                o_cs_n,
   output logic                o_wr_n,
   output logic                o_ldac_n,
   output logic                o_busy,
   output logic                o_overrun,
   input  logic                i_clr_overrun
);

   localparam int STRB_MAX = (WR_CYC > LDAC_CYC) ? WR_CYC : LDAC_CYC;
   localparam int STRB_W   = $clog2(STRB_MAX) + 1;

   logic                w_press;
   logic [MODE_W-1:0]   r_mode;

   logic                r_en_d;
   logic                w_en_rise;
   logic [PERIOD_W-1:0] r_shadow;
   logic [PERIOD_W-1:0] w_period_sel;
   logic [PERIOD_W-1:0] w_period_eff;
   logic [PERIOD_W-1:0] r_cnt;
   logic                w_tick;

   wr_state_t           r_state;
   wr_state_t           w_state_nxt;
   logic [STRB_W-1:0]   r_strb;
   logic [STRB_W-1:0]   w_strb_nxt;
   logic                w_load;

   logic                r_ack;
   logic [DAC_W-1:0]    r_dac;
   logic                r_cs_n;
   logic                r_wr_n;
   logic                r_ldac_n;
   logic                r_ovr;

   dac_write_scheduler_btn_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_btn_debounce (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_btn_n (i_btn_n),
      .o_press (w_press)
   );

   // Each accepted press advances the mode, wrapping 7 -> 0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        r_mode <= '0;
      else if (w_press) r_mode <= r_mode + 1'b1;
   end

   // On the enable rising edge the live period is used directly so the very
   // first period already honours period_in rather than a stale shadow.
   assign w_en_rise    = i_enable & ~r_en_d;
   assign w_period_sel = w_en_rise ? i_period_in : r_shadow;
   assign w_period_eff = eff_period(w_period_sel, PERIOD_W'(MIN_PERIOD));
   assign w_tick       = i_enable & (r_cnt >= (w_period_eff - PERIOD_W'(1)));

   // Period counter; shadow reloads only at wrap or enable rise.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_en_d   <= 1'b0;
         r_cnt    <= '0;
         r_shadow <= '0;
      end else begin
         r_en_d <= i_enable;
         if (!i_enable) begin
            r_cnt <= '0;
         end else if (w_tick) begin
            r_cnt    <= '0;
            r_shadow <= i_period_in;
         end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_en_rise) r_shadow <= i_period_in;
         end
      end
   end

   // Write sequence next-state and strobe-length down-counter.
   always_comb begin
      w_state_nxt = r_state;
      w_strb_nxt  = r_strb;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_tick) begin
               w_state_nxt = ST_SETUP;
               w_load      = 1'b1;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_WRITE;
            w_strb_nxt  = STRB_W'(WR_CYC - 1);
         end
         ST_WRITE: begin
            if (r_strb == '0) w_state_nxt = ST_HOLD;
            else              w_strb_nxt  = r_strb - 1'b1;
         end
         ST_HOLD: begin
            w_state_nxt = ST_LOAD;
            w_strb_nxt  = STRB_W'(LDAC_CYC - 1);
         end
         ST_LOAD: begin
            if (r_strb == '0) w_state_nxt = ST_IDLE;
            else              w_strb_nxt  = r_strb - 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_strb  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_strb  <= w_strb_nxt;
      end
   end

   // Strobes registered from the next state so the DAC pins never glitch;
   // reset forces them high at once, so no partial LDAC can follow a reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ack    <= 1'b0;
         r_dac    <= '0;
         r_cs_n   <= 1'b1;
         r_wr_n   <= 1'b1;
         r_ldac_n <= 1'b1;
      end else begin
         r_ack    <= w_load;
         if (w_load) r_dac <= i_sample_in;
         r_cs_n   <= ~((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_WRITE) ||
                       (w_state_nxt == ST_HOLD));
         r_wr_n   <= (w_state_nxt != ST_WRITE);
         r_ldac_n <= (w_state_nxt != ST_LOAD);
      end
   end

   // Sticky overrun: a dropped tick sets it and takes priority over clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                              r_ovr <= 1'b0;
      else if (w_tick && (r_state != ST_IDLE)) r_ovr <= 1'b1;
      else if (i_clr_overrun)                 r_ovr <= 1'b0;
   end

   assign o_mode       = r_mode;
   assign o_sample_ack = r_ack;
   assign o_dac_data   = r_dac;
   assign o_cs_n       = r_cs_n;
   assign o_wr_n       = r_wr_n;
   assign o_ldac_n     = r_ldac_n;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_overrun    = r_ovr;

endmodule
